avalon_pio_out_gen: RTL and testbench

- Parametrised successor to the team's fixed 8-bit Avalon-MM output PIO.
- Adds configurable width, write-1-to-set/clear aliases, self-clearing timed pulse outputs, and a synchronised input port with rising-edge capture and a maskable interrupt.
- Sits on the Qsys/Avalon-MM fabric as a zero-wait-state slave.
- Drives control strobes such as start signals to datapath blocks and returns their done flags to the CPU.

---
 rtl/avalon_pio_out_gen.sv | 144 ++++++++++++++
 tb/tb_avalon_pio_out_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_out_gen.sv
// rtl/avalon_pio_out_gen.sv - parametrised Avalon-MM output PIO with set/clear aliases, timed pulses and edge-capture irq
module avalon_pio_out_gen #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_IN      = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGE    = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;
  localparam logic [2:0] A_PULSE   = 3'd6;
  localparam logic [2:0] A_STATUS  = 3'd7;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_wdata;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] edge_clr;
  logic [DATA_WIDTH-1:0] sync_meta;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] pulse_bits;
  logic [CNT_W-1:0]      pulse_cnt;
  logic                  pulse_wr;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rd_val;

  // Bits of writedata above DATA_WIDTH are architecturally ignored.
  assign unused_wdata = ^writedata;
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign wr_en        = chipselect & ~write_n;
  assign pulse_wr     = wr_en && (address == A_PULSE) && (wdata != '0);
  assign edge_clr     = (wr_en && (address == A_EDGE)) ? wdata : '0;
  assign busy         = (pulse_cnt != '0);
  assign out_port     = data_out | pulse_bits;

  // DATA register with direct, set-alias and clear-alias writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        A_DATA:   data_out <= wdata;
        A_OUTSET: data_out <= data_out | wdata;
        A_OUTCLR: data_out <= data_out & ~wdata;
        default:  data_out <= data_out;
      endcase
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask <= '0;
    end else if (wr_en && (address == A_IRQMASK)) begin
      irqmask <= wdata;
    end
  end

  // Two-flop synchroniser plus the delayed copy used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      in_sync   <= '0;
      prev      <= '0;
    end else begin
      sync_meta <= in_port;
      in_sync   <= sync_meta;
      prev      <= in_sync;
    end
  end

  // Sticky rising-edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | (in_sync & ~prev);
    end
  end

  // Registered interrupt from masked captured edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irqmask);
    end
  end

  // Self-clearing pulse: a write reloads the timer; landing on the expiry edge keeps only the new bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_bits <= '0;
      pulse_cnt  <= '0;
    end else if (pulse_wr) begin
      pulse_bits <= (pulse_cnt == CNT_ONE) ? wdata : (pulse_bits | wdata);
      pulse_cnt  <= CNT_LOAD;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - CNT_ONE;
      if (pulse_cnt == CNT_ONE) begin
        pulse_bits <= '0;
      end
    end
  end

  // Zero-wait-state read decode, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    case (address)
      A_DATA:    rd_val = data_out;
      A_IN:      rd_val = in_sync;
      A_IRQMASK: rd_val = irqmask;
      A_EDGE:    rd_val = edge_cap;
      A_PULSE:   rd_val = pulse_bits;
      default:   rd_val = '0;
    endcase
    readdata = 32'(rd_val);
    if (address == A_STATUS) begin
      readdata = {31'b0, busy};
    end
  end

endmodule

// File: tb/tb_avalon_pio_out_gen.sv
// tb/tb_avalon_pio_out_gen.sv - self-checking bench for avalon_pio_out_gen
`timescale 1ns/1ps
module tb_avalon_pio_out_gen;

  localparam int         DW = 8;
  localparam logic [7:0] RV = 8'hA5;
  localparam int         PC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: DATA value plus the pulse as a set of bits and the edge index where it ends.
  logic [7:0] m_data = RV;
  logic [7:0] m_bits = '0;
  int         m_end  = 0;

  avalon_pio_out_gen #(
    .DATA_WIDTH(DW),
    .RESET_VALUE(RV),
    .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .out_port(out_port),
    .irq(irq)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_out(input int m);
    return m_data | ((m < m_end) ? m_bits : 8'h00);
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d, input int n);
    case (a)
      3'd0: m_data = d[7:0];
      3'd4: m_data = m_data | d[7:0];
      3'd5: m_data = m_data & ~d[7:0];
      3'd6: if (d[7:0] != 8'h00) begin
        m_bits = (n < m_end) ? (m_bits | d[7:0]) : d[7:0];
        m_end  = n + PC;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    model_write(a, d, cyc);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    m_data = RV;
    m_end  = 0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      checks++;
      if (v !== ((i == 0) ? 32'h0000_00A5 : 32'h0)) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", i, v, (i == 0) ? 32'hA5 : 32'h0);
      end
    end
    checks++;
    if (out_port !== RV) begin
      errors++;
      $display("FAIL reset_out_port got=%h exp=%h", out_port, RV);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_data_regs();
    logic [31:0] v;
    logic [2:0]  a;
    logic [31:0] d;
    wr(3'd0, 32'h3C);
    checks++;
    if (out_port !== 8'h3C) begin errors++; $display("FAIL data_write got=%h exp=3c", out_port); end
    wr(3'd4, 32'h81);
    checks++;
    if (out_port !== 8'hBD) begin errors++; $display("FAIL outset got=%h exp=bd", out_port); end
    wr(3'd5, 32'h0C);
    checks++;
    if (out_port !== 8'hB1) begin errors++; $display("FAIL outclr got=%h exp=b1", out_port); end
    wr(3'd0, 32'hFFFF_FF12);
    rd(3'd0, v);
    checks++;
    if (v !== 32'h0000_0012) begin errors++; $display("FAIL data_upper_ignored got=%h exp=00000012", v); end
    rd(3'd4, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL outset_reads_zero got=%h exp=0", v); end
    rd(3'd5, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL outclr_reads_zero got=%h exp=0", v); end
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 3'd0;
        1:       a = 3'd4;
        default: a = 3'd5;
      endcase
      d = $urandom;
      wr(a, d);
      checks++;
      if (out_port !== exp_out(cyc)) begin
        errors++;
        $display("FAIL rand_data_out it=%0d addr=%0d got=%h exp=%h", i, a, out_port, exp_out(cyc));
      end
      rd(3'd0, v);
      checks++;
      if (v !== {24'h0, m_data}) begin
        errors++;
        $display("FAIL rand_data_read it=%0d got=%h exp=%h", i, v, {24'h0, m_data});
      end
    end
  endtask

  task automatic test_pulse();
    logic [31:0] v;
    wr(3'd0, 32'h00);
    wr(3'd6, 32'h01);
    for (int k = 0; k < PC + 2; k++) begin
      checks++;
      if (out_port !== ((k < PC) ? 8'h01 : 8'h00)) begin
        errors++;
        $display("FAIL pulse_out k=%0d got=%h exp=%h", k, out_port, (k < PC) ? 8'h01 : 8'h00);
      end
      rd(3'd7, v);
      checks++;
      if (v !== ((k < PC) ? 32'h1 : 32'h0)) begin
        errors++;
        $display("FAIL pulse_status k=%0d got=%h exp=%h", k, v, (k < PC) ? 32'h1 : 32'h0);
      end
      step();
    end
  endtask

  task automatic test_pulse_retrigger();
    wr(3'd6, 32'h01);
    step();
    wr(3'd6, 32'h02);
    for (int k = 0; k < PC + 2; k++) begin
      checks++;
      if (out_port !== ((k < PC) ? 8'h03 : 8'h00)) begin
        errors++;
        $display("FAIL retrigger k=%0d got=%h exp=%h", k, out_port, (k < PC) ? 8'h03 : 8'h00);
      end
      step();
    end
    wr(3'd6, 32'h01);
    repeat (PC - 1) step();
    wr(3'd6, 32'h02);
    for (int k = 0; k < PC + 1; k++) begin
      checks++;
      if (out_port !== ((k < PC) ? 8'h02 : 8'h00)) begin
        errors++;
        $display("FAIL expiry_edge_write k=%0d got=%h exp=%h", k, out_port, (k < PC) ? 8'h02 : 8'h00);
      end
      step();
    end
  endtask

  task automatic test_pulse_and_data();
    wr(3'd6, 32'h81);
    step();
    wr(3'd4, 32'h80);
    for (int k = 0; k < PC + 1; k++) begin
      checks++;
      if (out_port !== exp_out(cyc)) begin
        errors++;
        $display("FAIL overlap k=%0d got=%h exp=%h", k, out_port, exp_out(cyc));
      end
      step();
    end
    checks++;
    if (out_port !== 8'h80) begin errors++; $display("FAIL overlap_final got=%h exp=80", out_port); end
  endtask

  task automatic test_random_pulse();
    logic [31:0] v;
    logic [2:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        case ($urandom_range(0, 4))
          0:       a = 3'd0;
          1:       a = 3'd4;
          2:       a = 3'd5;
          default: a = 3'd6;
        endcase
        d = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        wr(a, d);
      end
      checks++;
      if (out_port !== exp_out(cyc)) begin
        errors++;
        $display("FAIL rand_pulse_out it=%0d got=%h exp=%h", i, out_port, exp_out(cyc));
      end
      rd(3'd7, v);
      checks++;
      if (v !== {31'h0, cyc < m_end}) begin
        errors++;
        $display("FAIL rand_pulse_busy it=%0d got=%h exp=%0d", i, v, cyc < m_end);
      end
      rd(3'd6, v);
      checks++;
      if (v !== {24'h0, (cyc < m_end) ? m_bits : 8'h00}) begin
        errors++;
        $display("FAIL rand_pulse_bits it=%0d got=%h exp=%h", i, v, (cyc < m_end) ? m_bits : 8'h00);
      end
    end
    repeat (PC + 1) step();
  endtask

  task automatic test_edge_irq();
    logic [31:0] v;
    wr(3'd2, 32'h04);
    #3;
    in_port = 8'h04;
    for (int e = 0; e < 4; e++) begin
      step();
      rd(3'd3, v);
      checks++;
      if (v !== ((e >= 2) ? 32'h4 : 32'h0)) begin
        errors++;
        $display("FAIL edge_latency e=%0d got=%h exp=%h", e, v, (e >= 2) ? 32'h4 : 32'h0);
      end
      checks++;
      if (irq !== (e >= 3)) begin
        errors++;
        $display("FAIL irq_latency e=%0d got=%b exp=%b", e, irq, e >= 3);
      end
    end
    rd(3'd1, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL in_read got=%h exp=4", v); end
    wr(3'd3, 32'h04);
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL edge_clear got=%h exp=0", v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_registered got=%b exp=1", irq); end
    for (int k = 0; k < 4; k++) begin
      step();
      rd(3'd3, v);
      checks++;
      if (v !== 32'h0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL hold_no_recapture k=%0d edge=%h irq=%b exp edge=0 irq=0", k, v, irq);
      end
    end
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] v;
    in_port = 8'h00;
    repeat (4) step();
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL fall_no_capture got=%h exp=0", v); end
    in_port = 8'h04;
    step();
    step();
    wr(3'd3, 32'h04);
    rd(3'd3, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL set_beats_clear got=%h exp=4", v); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_set got=%b exp=1", irq); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] v;
    wr(3'd6, 32'h10);
    checks++;
    if (out_port !== (m_data | 8'h10) || irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset out=%h irq=%b exp out=%h irq=1", out_port, irq, m_data | 8'h10);
    end
    reset      = 1'b1;
    address    = 3'd0;
    writedata  = 32'h77;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    in_port    = 8'h00;
    checks++;
    if (out_port !== RV) begin errors++; $display("FAIL reset_abort_out got=%h exp=%h", out_port, RV); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_abort_irq got=%b exp=0", irq); end
    rd(3'd7, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_abort_status got=%h exp=0", v); end
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_abort_edge got=%h exp=0", v); end
    rd(3'd0, v);
    checks++;
    if (v !== 32'hA5) begin errors++; $display("FAIL reset_priority_data got=%h exp=a5", v); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data_regs();
    test_pulse();
    test_pulse_retrigger();
    test_pulse_and_data();
    test_random_pulse();
    test_edge_irq();
    test_set_beats_clear();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
